// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH_ISSUE = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_DROP  = 2'd2,
    FETCH_HOLD  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Redirect targets are word aligned; low bits are forced to zero.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between fetch (master) and memory (slave).
interface if_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input rvalid, input rdata);
  modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/if_skid_buf.sv
// One-entry instruction+PC holding register used when IF/ID is stalled.
module if_skid_buf
  import if_fetch_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        pop_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear_i || pop_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= INSTR_NOP;
      pc_q    <= 32'h0000_0000;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: owns the PC, keeps one imem request in flight and feeds the IF/ID
// register, squashing the wrong path on a flush from the hazard detector.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  if_fetch_stage_if.master        imem,
  input  logic                    flush_i,
  input  logic [31:0]             redirect_pc_i,
  input  logic                    stall_i,
  output logic [31:0]             instr_o,
  output logic [31:0]             pc_o,
  output logic                    instr_valid_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic         valid_q, valid_d;
  logic         req_s;
  logic         skid_load_s, skid_pop_s, skid_clear_s;
  logic         skid_valid_s;
  logic [31:0]  skid_instr_s, skid_pc_s;
  logic [31:0]  redirect_s;
  logic         out_free_s;

  assign redirect_s = align_pc(redirect_pc_i);
  assign out_free_s = !valid_q || !stall_i;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q && stall_i;
    req_s        = 1'b0;
    skid_load_s  = 1'b0;
    skid_pop_s   = 1'b0;
    skid_clear_s = 1'b0;
    case (state_q)
      FETCH_ISSUE: begin
        if (flush_i) begin
          pc_d = redirect_s;
        end else if (out_free_s) begin
          req_s   = 1'b1;
          state_d = FETCH_WAIT;
        end else begin
          state_d = FETCH_ISSUE;
        end
      end
      FETCH_WAIT: begin
        if (flush_i) begin
          pc_d    = redirect_s;
          state_d = imem.rvalid ? FETCH_ISSUE : FETCH_DROP;
        end else if (imem.rvalid) begin
          pc_d = pc_q + PC_STEP;
          if (out_free_s) begin
            valid_d  = 1'b1;
            instr_d  = imem.rdata;
            pc_out_d = pc_q;
            state_d  = FETCH_ISSUE;
          end else begin
            skid_load_s = 1'b1;
            state_d     = FETCH_HOLD;
          end
        end else begin
          state_d = FETCH_WAIT;
        end
      end
      FETCH_DROP: begin
        // The stale response still in flight is swallowed here.
        if (flush_i) begin
          pc_d = redirect_s;
        end else begin
          pc_d = pc_q;
        end
        if (imem.rvalid) begin
          state_d = FETCH_ISSUE;
        end else begin
          state_d = FETCH_DROP;
        end
      end
      FETCH_HOLD: begin
        if (flush_i) begin
          skid_clear_s = 1'b1;
          pc_d         = redirect_s;
          state_d      = FETCH_ISSUE;
        end else if (!stall_i) begin
          skid_pop_s = 1'b1;
          valid_d    = skid_valid_s;
          instr_d    = skid_instr_s;
          pc_out_d   = skid_pc_s;
          state_d    = FETCH_ISSUE;
        end else begin
          state_d = FETCH_HOLD;
        end
      end
      default: begin
        state_d = FETCH_ISSUE;
      end
    endcase
    if (flush_i) begin
      valid_d = 1'b0;
      instr_d = INSTR_NOP;
    end else begin
      instr_d = instr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= FETCH_ISSUE;
      pc_q     <= RESET_PC;
      instr_q  <= INSTR_NOP;
      pc_out_q <= 32'h0000_0000;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  if_skid_buf u_skid (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (skid_load_s),
    .pop_i   (skid_pop_s),
    .clear_i (skid_clear_s),
    .instr_i (imem.rdata),
    .pc_i    (pc_q),
    .valid_o (skid_valid_s),
    .instr_o (skid_instr_s),
    .pc_o    (skid_pc_s)
  );

  // Request is combinational so a redirect reaches memory the very next cycle.
  assign imem.req      = req_s && rst_ni;
  assign imem.addr     = pc_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_out_q;
  assign instr_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed vector table plus randomized run against a fetch-stream scoreboard.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst_ni;
  logic        flush;
  logic [31:0] redirect;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        valid;

  if_fetch_stage_if imem_bus ();

  if_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .imem          (imem_bus),
    .flush_i       (flush),
    .redirect_pc_i (redirect),
    .stall_i       (stall),
    .instr_o       (instr),
    .pc_o          (pc),
    .instr_valid_o (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        flush;
    logic [31:0] redir;
    logic        stall;
    logic        rvalid;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs [21];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t mk(input logic f, input logic [31:0] rd, input logic s,
                              input logic rv, input logic [31:0] dat,
                              input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep,
                              input logic [31:0] ei);
    vec_t v;
    v.flush = f; v.redir = rd; v.stall = s; v.rvalid = rv; v.rdata = dat;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep; v.exp_instr = ei;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard state for the randomized run.
  logic [31:0] exp_req_pc, exp_out_pc, pend_addr;
  logic        pend, prev_flush;
  int          pend_cnt, accepted, idle_cycles;
  logic        hung;

  initial begin
    rst_ni = 1'b0; flush = 1'b0; redirect = 32'h0; stall = 1'b0;
    imem_bus.rvalid = 1'b0; imem_bus.rdata = 32'h0;

    vecs[0]  = mk(0, 32'h0, 0, 0, JUNK, 1, 32'h100, 0, 32'h0, NOP);
    vecs[1]  = mk(0, 32'h0, 0, 1, mem_word(32'h100), 0, 32'h0, 0, 32'h0, NOP);
    vecs[2]  = mk(0, 32'h0, 0, 0, JUNK, 1, 32'h104, 1, 32'h100, mem_word(32'h100));
    vecs[3]  = mk(0, 32'h0, 0, 1, mem_word(32'h104), 0, 32'h0, 0, 32'h0, mem_word(32'h100));
    vecs[4]  = mk(0, 32'h0, 0, 0, JUNK, 1, 32'h108, 1, 32'h104, mem_word(32'h104));
    vecs[5]  = mk(1, 32'h2002, 0, 0, JUNK, 0, 32'h0, 0, 32'h0, mem_word(32'h104));
    vecs[6]  = mk(0, 32'h0, 0, 0, JUNK, 0, 32'h0, 0, 32'h0, NOP);
    vecs[7]  = mk(0, 32'h0, 0, 1, mem_word(32'h108), 0, 32'h0, 0, 32'h0, NOP);
    vecs[8]  = mk(0, 32'h0, 0, 0, JUNK, 1, 32'h2000, 0, 32'h0, NOP);
    vecs[9]  = mk(1, 32'h3000, 0, 1, mem_word(32'h2000), 0, 32'h0, 0, 32'h0, NOP);
    vecs[10] = mk(0, 32'h0, 0, 0, JUNK, 1, 32'h3000, 0, 32'h0, NOP);
    vecs[11] = mk(0, 32'h0, 1, 1, mem_word(32'h3000), 0, 32'h0, 0, 32'h0, NOP);
    vecs[12] = mk(0, 32'h0, 1, 0, JUNK, 0, 32'h0, 1, 32'h3000, mem_word(32'h3000));
    vecs[13] = mk(0, 32'h0, 1, 0, JUNK, 0, 32'h0, 1, 32'h3000, mem_word(32'h3000));
    vecs[14] = mk(0, 32'h0, 0, 0, JUNK, 1, 32'h3004, 1, 32'h3000, mem_word(32'h3000));
    vecs[15] = mk(0, 32'h0, 0, 1, mem_word(32'h3004), 0, 32'h0, 0, 32'h0, mem_word(32'h3000));
    vecs[16] = mk(1, 32'hFFFF_FFFC, 0, 0, JUNK, 0, 32'h0, 1, 32'h3004, mem_word(32'h3004));
    vecs[17] = mk(0, 32'h0, 0, 0, JUNK, 1, 32'hFFFF_FFFC, 0, 32'h0, NOP);
    vecs[18] = mk(0, 32'h0, 0, 1, mem_word(32'hFFFF_FFFC), 0, 32'h0, 0, 32'h0, NOP);
    vecs[19] = mk(0, 32'h0, 0, 0, JUNK, 1, 32'h0, 1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
    vecs[20] = mk(0, 32'h0, 0, 0, JUNK, 0, 32'h0, 0, 32'h0, mem_word(32'hFFFF_FFFC));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("rst_req",   {31'd0, imem_bus.req}, 32'd0);
    check32("rst_valid", {31'd0, valid}, 32'd0);
    check32("rst_instr", instr, NOP);
    check32("rst_pc",    pc, 32'h0);

    // Directed vector table
    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      rst_ni = 1'b1;
      flush = vecs[i].flush; redirect = vecs[i].redir; stall = vecs[i].stall;
      imem_bus.rvalid = vecs[i].rvalid; imem_bus.rdata = vecs[i].rdata;
      @(negedge clk);
      check32($sformatf("vec%0d_req", i), {31'd0, imem_bus.req}, {31'd0, vecs[i].exp_req});
      if (vecs[i].exp_req) check32($sformatf("vec%0d_addr", i), imem_bus.addr, vecs[i].exp_addr);
      check32($sformatf("vec%0d_valid", i), {31'd0, valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) check32($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      check32($sformatf("vec%0d_instr", i), instr, vecs[i].exp_instr);
    end

    // Reset asserted for one cycle while a request is outstanding
    @(posedge clk); #1;
    flush = 1'b0; stall = 1'b0; imem_bus.rvalid = 1'b0; rst_ni = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check32("midrst_req",   {31'd0, imem_bus.req}, 32'd0);
    check32("midrst_valid", {31'd0, valid}, 32'd0);
    check32("midrst_instr", instr, NOP);
    check32("midrst_pc",    pc, 32'h0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(negedge clk);
    check32("midrst_req_after", {31'd0, imem_bus.req}, 32'd1);
    check32("midrst_addr_after", imem_bus.addr, RST_PC);

    // Randomized run against a fetch-stream scoreboard
    @(posedge clk); #1;
    rst_ni = 1'b0; imem_bus.rvalid = 1'b0;
    repeat (2) @(posedge clk);
    exp_req_pc = RST_PC; exp_out_pc = RST_PC; pend = 1'b0; pend_cnt = 0; pend_addr = 32'h0;
    prev_flush = 1'b0; accepted = 0; idle_cycles = 0; hung = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      rst_ni = 1'b1;
      flush = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) redirect = 32'hFFFF_FFF0 | $urandom_range(0, 15);
      else redirect = $urandom;
      stall = ($urandom_range(0, 2) == 0);
      if (pend && pend_cnt == 1) begin
        imem_bus.rvalid = 1'b1; imem_bus.rdata = mem_word(pend_addr); pend = 1'b0;
      end else begin
        imem_bus.rvalid = 1'b0; imem_bus.rdata = $urandom;
        if (pend) pend_cnt--;
      end
      @(negedge clk);
      if (prev_flush) begin
        check32("rnd_flush_valid", {31'd0, valid}, 32'd0);
        check32("rnd_flush_nop", instr, NOP);
      end
      if (valid) begin
        check32("rnd_out_pc", pc, exp_out_pc);
        check32("rnd_out_instr", instr, mem_word(pc));
      end
      if (flush) check32("rnd_req_during_flush", {31'd0, imem_bus.req}, 32'd0);
      if (imem_bus.req) begin
        check32("rnd_req_addr", imem_bus.addr, exp_req_pc);
        check32("rnd_single_outstanding", {31'd0, pend}, 32'd0);
        pend = 1'b1; pend_cnt = $urandom_range(1, 3); pend_addr = imem_bus.addr;
        exp_req_pc = imem_bus.addr + 32'd4;
        idle_cycles = 0;
      end else begin
        idle_cycles++;
        if (idle_cycles > 30 && !hung) begin
          hung = 1'b1;
          check32("rnd_fetch_progress", idle_cycles, 32'd30);
        end
      end
      if (flush) begin
        exp_req_pc = redirect & 32'hFFFF_FFFC;
        exp_out_pc = redirect & 32'hFFFF_FFFC;
      end else if (valid && !stall) begin
        exp_out_pc = exp_out_pc + 32'd4;
        accepted++;
      end
      prev_flush = flush;
    end
    checks++;
    if (accepted < 100) begin
      failures++;
      $display("FAIL rnd_throughput: got %0d accepted instructions expected at least 100", accepted);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
